// File: rtl/morph_filter_chain_if.sv
// Video stream bundle between a pixel source and the morphology filter chain.
interface morph_filter_chain_if;
  logic        VSync;
  logic        VDE;
  logic [23:0] RGBin;
  logic [7:0]  Threshold;
  logic [2:0]  Mode;
  logic        DE_out;
  logic        ProcessOut;
  logic [23:0] DisplayOut;

  modport master (
    output VSync, VDE, RGBin, Threshold, Mode,
    input  DE_out, ProcessOut, DisplayOut
  );

  modport slave (
    input  VSync, VDE, RGBin, Threshold, Mode,
    output DE_out, ProcessOut, DisplayOut
  );
endinterface

// File: rtl/morph_filter_chain.sv
// Greyscale/threshold front end feeding a 3x3 binary dilate/erode/edge window
// built from two line buffers; every mode leaves the block 3 cycles after sampling.
module morph_filter_chain #(
  parameter int         MAX_W   = 1024,
  parameter int         CNT_W   = 11,
  parameter logic [7:0] THR_RST = 8'h80
) (
  input logic                 CLK,
  input logic                 RST,
  morph_filter_chain_if.slave vid
);
  localparam int               LB_AW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(MAX_W - 1);

  localparam logic [2:0] M_GREY = 3'd1;
  localparam logic [2:0] M_BIN  = 3'd2;
  localparam logic [2:0] M_DIL  = 3'd3;
  localparam logic [2:0] M_ERO  = 3'd4;
  localparam logic [2:0] M_EDGE = 3'd5;
  localparam logic [2:0] M_OVL  = 3'd6;

  logic             vs_prev_q, vde_prev_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       mode_q, mode_d;
  logic [7:0]       thr_q, thr_d;
  logic             vs_rise, vde_fall;
  logic [9:0]       sum_c;
  logic [7:0]       grey_c;
  logic             bin_c;

  logic             vde1_q, bin1_q, inr1_q, r1ok_q, r2ok_q;
  logic [23:0]      rgb1_q;
  logic [7:0]       grey1_q;
  logic [2:0]       mode1_q;
  logic [LB_AW-1:0] addr1_q;

  logic             vde2_q, bin2_q;
  logic [23:0]      rgb2_q;
  logic [7:0]       grey2_q;
  logic [2:0]       mode2_q;
  logic [2:0]       col0_q, col1_q, col2_q, col_new;

  logic             de_q, po_q, po_d;
  logic [23:0]      disp_q, disp_d;
  logic [8:0]       taps;
  logic             dil, ero, edg;

  logic             lb1_mem [MAX_W];
  logic             lb2_mem [MAX_W];
  logic             lb1_rd, lb2_rd;

  // VSync rise wins over a coincident VDE fall so the new frame starts at row 0.
  always_comb begin
    vs_rise  = vid.VSync & ~vs_prev_q;
    vde_fall = ~vid.VDE & vde_prev_q;
    x_d      = x_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    mode_d   = mode_q;
    thr_d    = thr_q;
    if (vs_rise) begin
      mode_d = vid.Mode;
      thr_d  = vid.Threshold;
      x_d    = '0;
      y_d    = '0;
      ovf_d  = 1'b0;
    end else if (vde_fall) begin
      x_d   = '0;
      ovf_d = 1'b0;
      if (y_q != '1) y_d = y_q + 1'b1;
    end else if (vid.VDE) begin
      if (x_q == X_LAST) ovf_d = 1'b1;
      else               x_d   = x_q + 1'b1;
    end
    sum_c  = {2'b00, vid.RGBin[23:16]} + {1'b0, vid.RGBin[15:8], 1'b0} + {2'b00, vid.RGBin[7:0]};
    grey_c = 8'(sum_c >> 2);
    bin_c  = (grey_c >= thr_d);
  end

  // Column bits are {row y, row y-1, row y-2}; rows above the frame and pixels past the buffer read 0.
  always_comb begin
    lb1_rd  = lb1_mem[addr1_q];
    lb2_rd  = lb2_mem[addr1_q];
    col_new = {bin1_q & inr1_q, lb1_rd & inr1_q & r1ok_q, lb2_rd & inr1_q & r2ok_q};
  end

  always_comb begin
    taps   = {col2_q, col1_q, col0_q};
    dil    = |taps;
    ero    = &taps;
    edg    = col1_q[1] & ~ero;
    disp_d = '0;
    po_d   = 1'b0;
    if (vde2_q) begin
      case (mode2_q)
        M_GREY:  begin disp_d = {3{grey2_q}};                  po_d = grey2_q[7]; end
        M_BIN:   begin disp_d = {24{bin2_q}};                  po_d = bin2_q;     end
        M_DIL:   begin disp_d = {24{dil}};                     po_d = dil;        end
        M_ERO:   begin disp_d = {24{ero}};                     po_d = ero;        end
        M_EDGE:  begin disp_d = {24{edg}};                     po_d = edg;        end
        M_OVL:   begin disp_d = edg ? 24'hFF0000 : rgb2_q;     po_d = edg;        end
        default: begin disp_d = rgb2_q;                        po_d = grey2_q[7]; end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_prev_q  <= 1'b0;
      vde_prev_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      mode_q     <= '0;
      thr_q      <= THR_RST;
      vde1_q     <= 1'b0;
      bin1_q     <= 1'b0;
      inr1_q     <= 1'b0;
      r1ok_q     <= 1'b0;
      r2ok_q     <= 1'b0;
      rgb1_q     <= '0;
      grey1_q    <= '0;
      mode1_q    <= '0;
      addr1_q    <= '0;
      vde2_q     <= 1'b0;
      bin2_q     <= 1'b0;
      rgb2_q     <= '0;
      grey2_q    <= '0;
      mode2_q    <= '0;
      col0_q     <= '0;
      col1_q     <= '0;
      col2_q     <= '0;
      de_q       <= 1'b0;
      po_q       <= 1'b0;
      disp_q     <= '0;
    end else begin
      vs_prev_q  <= vid.VSync;
      vde_prev_q <= vid.VDE;
      x_q        <= x_d;
      y_q        <= y_d;
      ovf_q      <= ovf_d;
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      vde1_q     <= vid.VDE;
      bin1_q     <= bin_c;
      inr1_q     <= ~ovf_q;
      r1ok_q     <= (y_q != '0);
      r2ok_q     <= (y_q > CNT_W'(1));
      rgb1_q     <= vid.RGBin;
      grey1_q    <= grey_c;
      mode1_q    <= mode_d;
      addr1_q    <= x_q[LB_AW-1:0];
      vde2_q     <= vde1_q;
      bin2_q     <= bin1_q;
      rgb2_q     <= rgb1_q;
      grey2_q    <= grey1_q;
      mode2_q    <= mode1_q;
      if (vde1_q) begin
        col0_q <= col_new;
        col1_q <= col0_q;
        col2_q <= col1_q;
      end else begin
        col0_q <= '0;
        col1_q <= '0;
        col2_q <= '0;
      end
      de_q   <= vde2_q;
      po_q   <= po_d;
      disp_q <= disp_d;
    end
  end

  // Buffers are never cleared; row masking hides whatever a previous frame left.
  always_ff @(posedge CLK) begin
    if (!RST && vde1_q && inr1_q) begin
      lb1_mem[addr1_q] <= bin1_q;
      lb2_mem[addr1_q] <= lb1_mem[addr1_q];
    end
  end

  assign vid.DE_out     = de_q;
  assign vid.ProcessOut = po_q;
  assign vid.DisplayOut = disp_q;
endmodule

// File: tb/tb_morph_filter_chain.sv
// Directed bench for morph_filter_chain: a 1024-wide and a 16-wide instance share one stimulus stream.
module tb_morph_filter_chain;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  morph_filter_chain_if vif ();
  morph_filter_chain_if vif16 ();

  assign vif16.VSync     = vif.VSync;
  assign vif16.VDE       = vif.VDE;
  assign vif16.RGBin     = vif.RGBin;
  assign vif16.Threshold = vif.Threshold;
  assign vif16.Mode      = vif.Mode;

  morph_filter_chain dut (.CLK(clk), .RST(rst), .vid(vif));
  morph_filter_chain #(.MAX_W(16), .CNT_W(5), .THR_RST(8'h80)) dut16 (.CLK(clk), .RST(rst), .vid(vif16));

  typedef struct {
    logic        chk;
    logic        de;
    logic        po;
    logic [23:0] disp;
    logic        po16;
    logic [23:0] disp16;
    int          tx;
    int          ty;
  } exp_t;

  exp_t        expq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          ones     = 0;
  int          reds     = 0;
  string       test_name = "reset";
  logic [23:0] frame_rgb [0:7][0:19];
  logic        bimg      [0:7][0:19];
  int          fw = 0;
  int          fh = 0;

  function automatic logic [7:0] grey_of(input logic [23:0] p);
    int s;
    s = int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 4);
  endfunction

  function automatic logic pix(input int x, input int y, input int maxw);
    if (x < 0 || y < 0 || x >= maxw || x >= fw || y >= fh) return 1'b0;
    return bimg[y][x];
  endfunction

  // Returns {ProcessOut, DisplayOut} for window index (x,y) of the current frame image.
  function automatic logic [24:0] model(input int x, input int y, input logic [2:0] m, input int maxw);
    logic dil, ero, edg, t, b;
    logic [7:0] g;
    logic [23:0] p;
    dil = 1'b0;
    ero = 1'b1;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++) begin
        t = pix(x - i, y - j, maxw);
        dil = dil | t;
        ero = ero & t;
      end
    edg = pix(x - 1, y - 1, maxw) & ~ero;
    p = frame_rgb[y][x];
    g = grey_of(p);
    b = bimg[y][x];
    case (m)
      3'd1:    return {g[7], g, g, g};
      3'd2:    return {b, {24{b}}};
      3'd3:    return {dil, {24{dil}}};
      3'd4:    return {ero, {24{ero}}};
      3'd5:    return {edg, {24{edg}}};
      3'd6:    return {edg, edg ? 24'hFF0000 : p};
      default: return {g[7], p};
    endcase
  endfunction

  function automatic exp_t mk(input logic chk, input logic de, input logic po, input logic [23:0] disp);
    exp_t e;
    e.chk = chk; e.de = de; e.po = po; e.disp = disp; e.po16 = po; e.disp16 = disp;
    e.tx = -1; e.ty = -1;
    return e;
  endfunction

  function automatic exp_t idle();
    return mk(1'b1, 1'b0, 1'b0, 24'h0);
  endfunction

  function automatic exp_t pexp(input int x, input int y, input logic [2:0] m);
    exp_t e;
    logic [24:0] a, b;
    a = model(x, y, m, 1024);
    b = model(x, y, m, 16);
    e.chk = 1'b1; e.de = 1'b1; e.po = a[24]; e.disp = a[23:0];
    e.po16 = b[24]; e.disp16 = b[23:0]; e.tx = x; e.ty = y;
    return e;
  endfunction

  task automatic check(input exp_t c);
    n_assert++;
    assert (vif.DE_out === c.de && vif.ProcessOut === c.po && vif.DisplayOut === c.disp) else begin
      n_fail++;
      $error("FAIL %s x=%0d y=%0d: got de=%b po=%b disp=%h, want de=%b po=%b disp=%h",
             test_name, c.tx, c.ty, vif.DE_out, vif.ProcessOut, vif.DisplayOut, c.de, c.po, c.disp);
    end
    n_assert++;
    assert (vif16.DE_out === c.de && vif16.ProcessOut === c.po16 && vif16.DisplayOut === c.disp16) else begin
      n_fail++;
      $error("FAIL %s_w16 x=%0d y=%0d: got de=%b po=%b disp=%h, want de=%b po=%b disp=%h",
             test_name, c.tx, c.ty, vif16.DE_out, vif16.ProcessOut, vif16.DisplayOut, c.de, c.po16, c.disp16);
    end
    if (vif.ProcessOut === 1'b1) ones++;
    if (vif.DisplayOut === 24'hFF0000) reds++;
  endtask

  // Pushes the expectation for the cycle just driven; the entry from two ticks ago is now on the outputs.
  task automatic tick(input exp_t e);
    exp_t c;
    expq.push_back(e);
    @(posedge clk);
    #1;
    if (expq.size() >= 3) begin
      c = expq.pop_front();
      if (c.chk) check(c);
    end
  endtask

  task automatic count_check(input string tag, input int got, input int want);
    n_assert++;
    assert (got == want) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic run_frame(input int w, input int h, input logic [2:0] m, input logic [7:0] thr,
                           input int chg_line, input logic [2:0] chg_m);
    fw = w;
    fh = h;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 20; x++)
        bimg[y][x] = (grey_of(frame_rgb[y][x]) >= thr);
    vif.Mode = m;
    vif.Threshold = thr;
    vif.VSync = 1'b1;
    tick(idle());
    vif.VSync = 1'b0;
    tick(idle());
    tick(idle());
    ones = 0;
    reds = 0;
    for (int y = 0; y < h; y++) begin
      if (y == chg_line) begin
        vif.Mode = chg_m;
        vif.Threshold = ~thr;
      end
      for (int x = 0; x < w; x++) begin
        vif.VDE = 1'b1;
        vif.RGBin = frame_rgb[y][x];
        tick(pexp(x, y, m));
      end
      vif.VDE = 1'b0;
      vif.RGBin = 24'h0;
      tick(idle());
      tick(idle());
    end
  endtask

  task automatic fill_const(input logic [23:0] c);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 20; x++) frame_rgb[y][x] = c;
  endtask

  task automatic fill_square();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 20; x++)
        frame_rgb[y][x] = (x >= 2 && x <= 5 && y >= 2 && y <= 5) ? 24'hFFFFFF : 24'h000000;
  endtask

  task automatic fill_pattern();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 20; x++)
        frame_rgb[y][x] = ((x + 2 * y) % 3 != 0) ? 24'hC0C0C0 : 24'h202020;
  endtask

  initial begin
    rst = 1'b1;
    vif.VSync = 1'b0;
    vif.VDE = 1'b0;
    vif.RGBin = 24'h0;
    vif.Threshold = 8'h80;
    vif.Mode = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check(idle());
    rst = 1'b0;
    repeat (3) tick(idle());

    test_name = "mode0_pass";
    vif.VDE = 1'b1;
    vif.RGBin = 24'h123456;
    tick(mk(1'b1, 1'b1, 1'b0, 24'h123456));
    vif.VDE = 1'b0;
    vif.RGBin = 24'h0;
    repeat (3) tick(idle());

    test_name = "mode1_grey";
    vif.Mode = 3'd1;
    vif.VSync = 1'b1;
    tick(idle());
    vif.VSync = 1'b0;
    vif.Mode = 3'd0;
    tick(idle());
    vif.VDE = 1'b1;
    vif.RGBin = 24'h4080C0;
    tick(mk(1'b1, 1'b1, 1'b1, 24'h808080));
    vif.RGBin = 24'h102030;
    tick(mk(1'b1, 1'b1, 1'b0, 24'h202020));
    vif.VDE = 1'b0;
    vif.RGBin = 24'h0;
    repeat (3) tick(idle());

    test_name = "erode_white";
    fill_const(24'hFFFFFF);
    run_frame(8, 8, 3'd4, 8'h00, -1, 3'd0);
    count_check("erode_ones", ones, 36);
    test_name = "dilate_white";
    run_frame(8, 8, 3'd3, 8'h00, -1, 3'd0);
    count_check("dilate_ones", ones, 64);

    test_name = "edge_square";
    fill_square();
    run_frame(8, 8, 3'd5, 8'h80, -1, 3'd0);
    count_check("edge_ones", ones, 12);

    test_name = "mode2_midchange";
    run_frame(8, 8, 3'd2, 8'h80, 3, 3'd6);
    count_check("mode2_reds", reds, 0);
    test_name = "mode6_overlay";
    run_frame(8, 8, 3'd6, 8'h80, -1, 3'd0);
    count_check("overlay_reds", reds, 12);

    test_name = "mode7_pass";
    fill_pattern();
    run_frame(6, 2, 3'd7, 8'h80, -1, 3'd0);

    test_name = "wide_edge";
    run_frame(20, 4, 3'd5, 8'h80, -1, 3'd0);

    test_name = "midline_rst";
    vif.VDE = 1'b1;
    for (int x = 0; x < 5; x++) begin
      vif.RGBin = frame_rgb[0][x];
      tick(mk(1'b0, 1'b0, 1'b0, 24'h0));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    expq.delete();
    check(idle());
    rst = 1'b0;
    vif.VDE = 1'b0;
    vif.RGBin = 24'h0;
    repeat (3) tick(idle());

    test_name = "post_rst_line";
    for (int x = 0; x < 4; x++) begin
      vif.VDE = 1'b1;
      vif.RGBin = frame_rgb[0][x];
      tick(pexp(x, 0, 3'd0));
    end
    vif.VDE = 1'b0;
    vif.RGBin = 24'h0;
    repeat (3) tick(idle());

    test_name = "post_rst_frame";
    run_frame(20, 4, 3'd6, 8'h80, -1, 3'd0);
    repeat (3) tick(idle());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
